adt7410_i2c_target: RTL



---
 rtl/adt7410_i2c_pkg.sv | 23 ++
 rtl/adt7410_i2c_busmon.sv | 71 +++++++
 rtl/adt7410_i2c_target.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/adt7410_i2c_pkg.sv
// Shared types and constants for the ADT7410 I2C target emulation.
package adt7410_i2c_pkg;

    typedef enum logic [2:0] {
        stIdle,
        stAddr,
        stAddrAck,
        stWrByte,
        stWrAck,
        stRdByte,
        stRdAck,
        stIgnore
    } state_t;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    localparam logic [1:0] ONESHOT_MODE = 2'b01;

endpackage

// File: rtl/adt7410_i2c_busmon.sv
// SCL/SDA synchronizers and bus event detection (START, STOP, SCL edges).
// Define ADT7410_I2C_TARGET_GLITCH_FILTER_EN to add a 3-tap majority filter on both lines.
module adt7410_i2c_busmon (
    input  logic clk,
    input  logic rst,
    input  logic scl_line,
    input  logic sda_line,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_lvl;
    logic       sda_lvl;
    logic       scl_prev;
    logic       sda_prev;

    // Idle bus is high on both lines, so everything resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= '1;
            sda_meta <= '1;
        end else begin
            scl_meta <= {scl_meta[0], scl_line};
            sda_meta <= {sda_meta[0], sda_line};
        end
    end

`ifdef ADT7410_I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_taps;
    logic [1:0] sda_taps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_taps <= '1;
            sda_taps <= '1;
        end else begin
            scl_taps <= {scl_taps[0], scl_meta[1]};
            sda_taps <= {sda_taps[0], sda_meta[1]};
        end
    end

    // Majority of current sample and two previous: single-cycle pulses never win.
    assign scl_lvl = (scl_meta[1] & scl_taps[0]) | (scl_meta[1] & scl_taps[1]) | (scl_taps[0] & scl_taps[1]);
    assign sda_lvl = (sda_meta[1] & sda_taps[0]) | (sda_meta[1] & sda_taps[1]) | (sda_taps[0] & sda_taps[1]);
`else
    assign scl_lvl = scl_meta[1];
    assign sda_lvl = sda_meta[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
        end
    end

    assign scl_rise  = scl_lvl & ~scl_prev;
    assign scl_fall  = ~scl_lvl & scl_prev;
    assign start_det = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
    assign sda_sync  = sda_lvl;

endmodule

// File: rtl/adt7410_i2c_target.sv
// Bit-level I2C target emulating the ADT7410 register map (temperature, status, config, ID).
// Optional macro ADT7410_I2C_TARGET_GLITCH_FILTER_EN enables the bus glitch filter in the bus monitor.
module adt7410_i2c_target #(
    parameter logic [6:0] ADDR7        = 7'h48,
    parameter logic [7:0] CONFIG_RESET = 8'h00,
    parameter logic [7:0] ID_VALUE     = 8'hCB
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        SCL_i,
    input  logic        SDA_i,
    output logic        SDA_Drive_o,
    input  logic [15:0] Temperature_i,
    output logic [7:0]  Config_o,
    output logic        OneShot_o,
    output logic        Busy_o
);

    import adt7410_i2c_pkg::*;

    state_t      state;
    state_t      state_next;

    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        sda;

    logic [3:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [6:0]  txreg;
    logic [7:0]  pointer;
    logic [7:0]  config_reg;
    logic [15:0] shadow;
    logic        rw;
    logic        first_byte;
    logic        rd_ack;
    logic        sda_drive;
    logic        busy;
    logic        oneshot;

    logic        drive_next;
    logic        busy_next;
    logic        oneshot_next;

    logic [7:0]  rx_byte;
    logic [7:0]  rd_cur;
    logic [7:0]  rd_nxt;
    logic        byte_end;
    logic        addr_match;

    adt7410_i2c_busmon u_busmon (
        .clk       (Clk_i),
        .rst       (Reset_i),
        .scl_line  (SCL_i),
        .sda_line  (SDA_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda)
    );

    function automatic logic [7:0] read_reg(input logic [7:0] addr, input logic [15:0] shd,
                                            input logic [7:0] cfg);
        logic [7:0] val;
        case (addr)
            REG_TEMP_MSB: val = shd[15:8];
            REG_TEMP_LSB: val = shd[7:0];
            REG_STATUS:   val = 8'h00;
            REG_CONFIG:   val = cfg;
            REG_ID:       val = ID_VALUE;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

    assign rx_byte    = {shreg, sda};
    assign byte_end   = scl_rise && (bit_cnt == 4'd7);
    assign addr_match = (rx_byte[7:1] == ADDR7);
    assign rd_cur     = read_reg(pointer, shadow, config_reg);
    assign rd_nxt     = read_reg(pointer + 8'd1, shadow, config_reg);

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) state <= stIdle;
        else         state <= state_next;
    end

    // Ack states use the registered drive bit as phase: first SCL fall asserts, second ends the ACK.
    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = stAddr;
        end else if (stop_det) begin
            state_next = stIdle;
        end else begin
            case (state)
                stAddr:    if (byte_end) state_next = addr_match ? stAddrAck : stIgnore;
                stAddrAck: if (scl_fall && sda_drive) state_next = rw ? stRdByte : stWrByte;
                stWrByte:  if (byte_end) state_next = stWrAck;
                stWrAck:   if (scl_fall && sda_drive) state_next = stWrByte;
                stRdByte:  if (scl_fall && (bit_cnt == 4'd8)) state_next = stRdAck;
                stRdAck:   if (scl_fall) state_next = rd_ack ? stIgnore : stRdByte;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        drive_next   = sda_drive;
        busy_next    = busy;
        oneshot_next = 1'b0;
        if (start_det || stop_det) begin
            drive_next = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                stAddr:    if (byte_end && addr_match) busy_next = 1'b1;
                stAddrAck: if (scl_fall) drive_next = sda_drive ? (rw & ~rd_cur[7]) : 1'b1;
                stWrByte:  if (byte_end) oneshot_next = !first_byte && (pointer == REG_CONFIG) &&
                                                        (rx_byte[6:5] == ONESHOT_MODE);
                stWrAck:   if (scl_fall) drive_next = ~sda_drive;
                stRdByte:  if (scl_fall) drive_next = (bit_cnt == 4'd8) ? 1'b0 : ~txreg[6];
                stRdAck:   if (scl_fall) drive_next = rd_ack ? 1'b0 : ~rd_nxt[7];
                default:   drive_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            txreg      <= '0;
            pointer    <= '0;
            config_reg <= CONFIG_RESET;
            shadow     <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            rd_ack     <= 1'b1;
            sda_drive  <= 1'b0;
            busy       <= 1'b0;
            oneshot    <= 1'b0;
        end else begin
            sda_drive <= drive_next;
            busy      <= busy_next;
            oneshot   <= oneshot_next;
            if (start_det) begin
                bit_cnt <= '0;
            end else if (!stop_det) begin
                case (state)
                    stAddr: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
                        end
                        if (byte_end) begin
                            rw <= rx_byte[0];
                            // Shadow both temperature bytes so a read burst sees one sample.
                            if (addr_match && rx_byte[0]) shadow <= Temperature_i;
                        end
                    end
                    stAddrAck: begin
                        if (scl_fall && sda_drive) begin
                            bit_cnt    <= '0;
                            first_byte <= 1'b1;
                            txreg      <= rd_cur[6:0];
                        end
                    end
                    stWrByte: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
                        end
                        if (byte_end) begin
                            first_byte <= 1'b0;
                            if (first_byte) begin
                                pointer <= rx_byte;
                            end else begin
                                if (pointer == REG_CONFIG) config_reg <= rx_byte;
                                pointer <= pointer + 8'd1;
                            end
                        end
                    end
                    stRdByte: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall && (bit_cnt != 4'd8)) txreg <= {txreg[5:0], 1'b0};
                    end
                    stRdAck: begin
                        if (scl_rise) rd_ack <= sda;
                        if (scl_fall && !rd_ack) begin
                            pointer <= pointer + 8'd1;
                            txreg   <= rd_nxt[6:0];
                            bit_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_Drive_o = sda_drive;
    assign Config_o    = config_reg;
    assign OneShot_o   = oneshot;
    assign Busy_o      = busy;

endmodule
